// File: rtl/barrel_ctrl.sv
// barrel_ctrl: barrel slot manager for the game.
// Spawns a barrel on each rising edge of is_drop while playing, then rolls and
// drops it from platform to platform until it falls past the bottom row.
// Optional feature macro: BARREL_OVERFLOW_CNT_EN (saturating lost-spawn counter).
module barrel_ctrl #(
  parameter int unsigned NUM_BARRELS = 4,
  parameter int unsigned SPAWN_X     = 159,
  parameter int unsigned SPAWN_Y     = 95,
  parameter int unsigned LEFT_EDGE   = 16,
  parameter int unsigned RIGHT_EDGE  = 600,
  parameter int unsigned FALL_TICKS  = 32,
  parameter int unsigned BOTTOM_Y    = 447
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       over,
  input  logic                       is_drop,
  input  logic                       move_tick,
  output logic                       state,
  output logic [NUM_BARRELS-1:0]     barrel_valid,
  output logic [NUM_BARRELS-1:0]     barrel_falling,
  output logic [NUM_BARRELS*10-1:0]  barrel_x,
  output logic [NUM_BARRELS*9-1:0]   barrel_y,
  output logic                       spawn_ack,
  output logic [7:0]                 overflow_cnt
);

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned CNT_W = $clog2(FALL_TICKS + 1);

  typedef enum logic {
    ST_INITIAL = 1'b0,
    ST_PLAYING = 1'b1
  } game_state_t;

  game_state_t             st_q;
  logic                    drop_q;
  logic                    ack_q;
  logic [NUM_BARRELS-1:0]  valid_q;
  logic [NUM_BARRELS-1:0]  fall_q;
  logic [NUM_BARRELS-1:0]  dir_left_q;
  logic [X_W-1:0]          x_q   [NUM_BARRELS];
  logic [Y_W-1:0]          y_q   [NUM_BARRELS];
  logic [CNT_W-1:0]        cnt_q [NUM_BARRELS];

  logic                    go_initial;
  logic                    spawn_evt;
  logic                    move_en;
  logic                    has_free;
  logic [NUM_BARRELS-1:0]  spawn_hit;

  // Game-level control: over beats start, spawns only on a fresh is_drop edge
  assign go_initial = (st_q == ST_PLAYING) && over;
  assign spawn_evt  = (st_q == ST_PLAYING) && !over && is_drop && !drop_q;
  assign move_en    = (st_q == ST_PLAYING) && !over && move_tick;

  // Lowest-index slot free at the start of the cycle (a retiring slot is still busy)
  always_comb begin
    spawn_hit = '0;
    has_free  = 1'b0;
    for (int i = 0; i < NUM_BARRELS; i++) begin
      if (!valid_q[i] && !has_free) begin
        spawn_hit[i] = 1'b1;
        has_free     = 1'b1;
      end
    end
  end

  // Game FSM, is_drop edge register and spawn acknowledge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_INITIAL;
      drop_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      drop_q <= is_drop;
      ack_q  <= spawn_evt && has_free;
      case (st_q)
        ST_INITIAL: if (start) st_q <= ST_PLAYING;
        ST_PLAYING: if (over)  st_q <= ST_INITIAL;
        default:               st_q <= ST_INITIAL;
      endcase
    end
  end

  // Per-slot barrel state: clear, spawn, roll, fall, retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      fall_q     <= '0;
      dir_left_q <= '0;
      for (int i = 0; i < NUM_BARRELS; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BARRELS; i++) begin
        if (go_initial) begin
          valid_q[i]    <= 1'b0;
          fall_q[i]     <= 1'b0;
          dir_left_q[i] <= 1'b0;
          x_q[i]        <= '0;
          y_q[i]        <= '0;
          cnt_q[i]      <= '0;
        end else if (spawn_evt && spawn_hit[i]) begin
          valid_q[i]    <= 1'b1;
          fall_q[i]     <= 1'b0;
          dir_left_q[i] <= 1'b0;
          x_q[i]        <= X_W'(SPAWN_X);
          y_q[i]        <= Y_W'(SPAWN_Y);
          cnt_q[i]      <= '0;
        end else if (valid_q[i] && move_en) begin
          if (!fall_q[i]) begin
            // Roll; reaching an edge starts a fall without moving x
            if (!dir_left_q[i]) begin
              if (x_q[i] >= X_W'(RIGHT_EDGE)) fall_q[i] <= 1'b1;
              else                            x_q[i]    <= x_q[i] + X_W'(1);
            end else begin
              if (x_q[i] <= X_W'(LEFT_EDGE))  fall_q[i] <= 1'b1;
              else                            x_q[i]    <= x_q[i] - X_W'(1);
            end
          end else if (cnt_q[i] == CNT_W'(FALL_TICKS - 1)) begin
            // Last fall tick: retire below the bottom row, else roll back the other way
            cnt_q[i]  <= '0;
            fall_q[i] <= 1'b0;
            if (y_q[i] >= Y_W'(BOTTOM_Y - 2)) begin
              valid_q[i]    <= 1'b0;
              dir_left_q[i] <= 1'b0;
              x_q[i]        <= '0;
              y_q[i]        <= '0;
            end else begin
              y_q[i]        <= y_q[i] + Y_W'(2);
              dir_left_q[i] <= ~dir_left_q[i];
            end
          end else begin
            y_q[i]   <= y_q[i] + Y_W'(2);
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef BARREL_OVERFLOW_CNT_EN
  logic [7:0] ovf_q;

  // Saturating count of spawns lost to a full slot table
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       ovf_q <= '0;
    else if (go_initial)                           ovf_q <= '0;
    else if (spawn_evt && !has_free && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
  end

  assign overflow_cnt = ovf_q;
`else
  assign overflow_cnt = 8'd0;
`endif

  // Flatten slot registers onto the output buses
  always_comb begin
    barrel_x = '0;
    barrel_y = '0;
    for (int i = 0; i < NUM_BARRELS; i++) begin
      barrel_x[i*X_W +: X_W] = x_q[i];
      barrel_y[i*Y_W +: Y_W] = y_q[i];
    end
  end

  assign state          = st_q;
  assign barrel_valid   = valid_q;
  assign barrel_falling = fall_q;
  assign spawn_ack      = ack_q;

endmodule

// File: tb/tb_barrel_ctrl.sv
// Directed self-checking bench for barrel_ctrl.
module tb_barrel_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        over;
  logic        is_drop;
  logic        move_tick;
  logic        state;
  logic [3:0]  barrel_valid;
  logic [3:0]  barrel_falling;
  logic [39:0] barrel_x;
  logic [35:0] barrel_y;
  logic        spawn_ack;
  logic [7:0]  overflow_cnt;

  int checks = 0;
  int errors = 0;
  int acks;

`ifdef BARREL_OVERFLOW_CNT_EN
  localparam int OVF_EXP = 1;
`else
  localparam int OVF_EXP = 0;
`endif

  always #5 clk = ~clk;

  barrel_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .over           (over),
    .is_drop        (is_drop),
    .move_tick      (move_tick),
    .state          (state),
    .barrel_valid   (barrel_valid),
    .barrel_falling (barrel_falling),
    .barrel_x       (barrel_x),
    .barrel_y       (barrel_y),
    .spawn_ack      (spawn_ack),
    .overflow_cnt   (overflow_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] bx(input int i);
    return barrel_x[i*10 +: 10];
  endfunction

  function automatic logic [8:0] by(input int i);
    return barrel_y[i*9 +: 9];
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; over = 1'b0; is_drop = 1'b0; move_tick = 1'b0;
    step(2);
    check("rst_state", state, 0);
    check("rst_valid", barrel_valid, 0);
    check("rst_ack", spawn_ack, 0);
    check("rst_ovf", overflow_cnt, 0);
    rst = 1'b0;

    // Start, then a single spawn
    start = 1'b1; step(1); start = 1'b0;
    check("start_state", state, 1);
    is_drop = 1'b1; step(1);
    check("spawn_valid", barrel_valid, 4'b0001);
    check("spawn_x", bx(0), 159);
    check("spawn_y", by(0), 95);
    check("spawn_ack", spawn_ack, 1);
    step(1);
    check("ack_one_cycle", spawn_ack, 0);
    is_drop = 1'b0; step(1);

    // Roll right to the edge, fall one platform, roll left
    move_tick = 1'b1;
    step(441);
    check("roll_x600", bx(0), 600);
    check("roll_not_fall", barrel_falling, 0);
    step(1);
    check("edge_falling", barrel_falling, 4'b0001);
    check("edge_x_hold", bx(0), 600);
    step(32);
    check("fall_end_y", by(0), 159);
    check("fall_end_flag", barrel_falling, 0);
    step(1);
    check("roll_left_x", bx(0), 599);

    // Run up to the tick before the sixth fall ends
    step(3083);
    move_tick = 1'b0;
    check("pre_retire_fall", barrel_falling, 4'b0001);
    check("pre_retire_y", by(0), 477);
    check("pre_retire_x", bx(0), 16);

    // Fill slots 1 and 2
    is_drop = 1'b1; step(1); is_drop = 1'b0; step(1);
    is_drop = 1'b1; step(1); is_drop = 1'b0; step(1);
    check("fill_valid", barrel_valid, 4'b0111);

    // Retire slot 0 while spawning: new barrel must go to slot 3
    move_tick = 1'b1; is_drop = 1'b1; step(1); move_tick = 1'b0;
    check("retire_valid", barrel_valid, 4'b1110);
    check("retire_x0", bx(0), 0);
    check("retire_y0", by(0), 0);
    check("retire_spawn_x3", bx(3), 159);
    check("retire_ack", spawn_ack, 1);
    check("others_moved", bx(1), 160);
    is_drop = 1'b0; step(1);
    is_drop = 1'b1; step(1);
    check("reuse_valid", barrel_valid, 4'b1111);
    check("reuse_y0", by(0), 95);
    is_drop = 1'b0; step(1);

    // Lost spawn with every slot busy
    is_drop = 1'b1; step(1);
    check("full_valid", barrel_valid, 4'b1111);
    check("full_ack", spawn_ack, 0);
    check("full_ovf", overflow_cnt, OVF_EXP);
    is_drop = 1'b0; step(1);

    // start and over together: over wins and clears everything
    start = 1'b1; over = 1'b1; step(1); start = 1'b0; over = 1'b0;
    check("over_state", state, 0);
    check("over_valid", barrel_valid, 0);
    check("over_x", barrel_x, 0);
    check("over_y", barrel_y, 0);
    check("over_ovf", overflow_cnt, 0);

    // is_drop held across start gives no spawn until a fresh edge
    is_drop = 1'b1; step(1);
    check("init_ignore", barrel_valid, 0);
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    check("held_no_spawn", barrel_valid, 0);
    acks = 0;
    is_drop = 1'b0; step(1);
    is_drop = 1'b1; step(1);
    if (spawn_ack) acks++;
    check("fresh_edge_spawn", barrel_valid, 4'b0001);

    // Four more edges with no movement: one of the five is lost
    for (int k = 0; k < 4; k++) begin
      is_drop = 1'b0; step(1);
      is_drop = 1'b1; step(1);
      if (spawn_ack) acks++;
    end
    is_drop = 1'b0; step(1);
    check("five_valid", barrel_valid, 4'b1111);
    check("five_acks", acks, 4);
    check("five_ovf", overflow_cnt, OVF_EXP);

    // Asynchronous reset in the middle of a fall
    move_tick = 1'b1;
    step(445);
    check("all_falling", barrel_falling, 4'b1111);
    #2 rst = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_valid", barrel_valid, 0);
    check("arst_falling", barrel_falling, 0);
    check("arst_x", barrel_x, 0);
    check("arst_ovf", overflow_cnt, 0);
    move_tick = 1'b0;
    step(1);
    rst = 1'b0;

    // After reset a drop edge without start does nothing
    is_drop = 1'b1; step(1);
    check("post_rst_no_spawn", barrel_valid, 0);
    is_drop = 1'b0; step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
